// File: rtl/rf_ppm_decoder_if.sv
// Decoder-side bundle: frame strobe and RF level in, decoded word out on valid/ready, plus status pulses.
interface rf_ppm_decoder_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 14
);
    logic              frame_stb;
    logic              rf_evt;
    logic              data_ready;
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              overflow;
    logic              frame_err;
    logic [1:0]        err_code;
    logic [CNT_W-1:0]  pos_last;

    modport master (
        output frame_stb, rf_evt, data_ready,
        input  data_out, data_valid, overflow, frame_err, err_code, pos_last
    );

    modport slave (
        input  frame_stb, rf_evt, data_ready,
        output data_out, data_valid, overflow, frame_err, err_code, pos_last
    );
endinterface

// File: rtl/rf_ppm_decoder.sv
// PPM decoder: one RF pulse per strobe frame, early = 0 / late = 1, bits packed MSB first into words.
// Latency: a word is valid 1 clk after the strobe that closes its last frame.
// Backpressure: one-word holding register; a word completing while it is still full is dropped and flagged.
module rf_ppm_decoder #(
    parameter int WORD_W     = 8,
    parameter int CNT_W      = 14,
    parameter int BIT_THRESH = 5000
) (
    input  logic            clk,
    input  logic            rst,
    rf_ppm_decoder_if.slave bus
);

    localparam int BC_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GOT,
        S_DBL
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rf_q, rf_d;
    logic [CNT_W-1:0]  pos_q, pos_d;
    logic [CNT_W-1:0]  pos_last_q, pos_last_d;
    logic [WORD_W-2:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              ferr_q, ferr_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              edge_det;
    logic              new_bit;
    logic              word_done;
    logic              hs;
    logic [WORD_W-1:0] shifted;

    always_comb begin
        state_d    = state_q;
        rf_d       = bus.rf_evt;
        pos_d      = pos_q;
        pos_last_d = pos_last_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ovf_d      = 1'b0;
        ferr_d     = 1'b0;
        err_code_d = err_code_q;
        word_done  = 1'b0;

        edge_det = bus.rf_evt & ~rf_q;
        new_bit  = (32'(pos_q) >= BIT_THRESH);
        shifted  = {shreg_q, new_bit};
        hs       = valid_q & bus.data_ready;

        // The counter value seen during a cycle is the position of that cycle; the strobe cycle is 0.
        if (bus.frame_stb) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (hs) begin
            valid_d = 1'b0;
        end

        if (bus.frame_stb) begin
            // Close the finishing frame first, then open the new one.
            unique case (state_q)
                S_WAIT: begin
                    ferr_d     = 1'b1;
                    err_code_d = 2'b01;
                    bit_cnt_d  = '0;
                    shreg_d    = '0;
                end
                S_GOT: begin
                    if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
                        word_done = 1'b1;
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        shreg_d   = shifted[WORD_W-2:0];
                    end
                end
                S_DBL: begin
                    ferr_d     = 1'b1;
                    err_code_d = 2'b10;
                    bit_cnt_d  = '0;
                    shreg_d    = '0;
                end
                default: ;
            endcase

            if (edge_det) begin
                state_d    = S_GOT;
                pos_d      = '0;
                pos_last_d = '0;
            end else begin
                state_d = S_WAIT;
            end
        end else if (edge_det) begin
            unique case (state_q)
                S_WAIT: begin
                    state_d    = S_GOT;
                    pos_d      = cnt_d;
                    pos_last_d = cnt_d;
                end
                S_GOT:   state_d = S_DBL;
                default: ;
            endcase
        end

        // A word being consumed this cycle frees the holding register for the new one.
        if (word_done) begin
            if (!valid_q || hs) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rf_q       <= 1'b0;
            pos_q      <= '0;
            pos_last_q <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_q       <= rf_d;
            pos_q      <= pos_d;
            pos_last_q <= pos_last_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.overflow   = ovf_q;
    assign bus.frame_err  = ferr_q;
    assign bus.err_code   = err_code_q;
    assign bus.pos_last   = pos_last_q;

endmodule

// File: tb/tb_rf_ppm_decoder.sv
// Bench for rf_ppm_decoder with scaled frames (threshold 50, 8-bit position counter, 120-clk frames).
module tb_rf_ppm_decoder;

    localparam int THR = 50;
    localparam int PMAX = 255;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    rf_ppm_decoder_if #(.WORD_W(8), .CNT_W(8)) bus ();

    rf_ppm_decoder #(.WORD_W(8), .CNT_W(8), .BIT_THRESH(THR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Frame-level reference model state
    bit         m_armed, m_prev_rf;
    int         m_pos_now, m_npulse, m_pos;
    bit         bits[$];
    logic       m_valid, m_ovf, m_ferr;
    logic [7:0] m_data, m_pos_last;
    logic [1:0] m_err_code;
    logic [7:0] model_words[$];
    logic [7:0] dut_words[$];
    int         dut_ferr_cnt = 0;
    int         dut_ovf_cnt = 0;
    bit         rand_ready = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_prev_rf = 0; m_pos_now = 0; m_npulse = 0; m_pos = 0;
        bits.delete();
        m_valid = 0; m_ovf = 0; m_ferr = 0; m_data = '0; m_pos_last = '0; m_err_code = '0;
    endtask

    task automatic model_step();
        bit         stb, edg, hs;
        logic [7:0] w;
        stb = bus.frame_stb;
        edg = bus.rf_evt && !m_prev_rf;
        hs  = m_valid && bus.data_ready;
        m_prev_rf = bus.rf_evt;
        m_pos_now = stb ? 0 : ((m_pos_now < PMAX) ? m_pos_now + 1 : PMAX);
        m_ovf = 0;
        m_ferr = 0;
        if (hs) begin
            model_words.push_back(m_data);
            m_valid = 0;
        end
        if (stb) begin
            if (m_armed) begin
                if (m_npulse == 0) begin
                    m_ferr = 1; m_err_code = 2'b01; bits.delete();
                end else if (m_npulse > 1) begin
                    m_ferr = 1; m_err_code = 2'b10; bits.delete();
                end else begin
                    bits.push_back(m_pos >= THR);
                    if (bits.size() == 8) begin
                        w = '0;
                        foreach (bits[i]) w = {w[6:0], bits[i]};
                        bits.delete();
                        if (m_valid) m_ovf = 1;
                        else begin
                            m_data = w;
                            m_valid = 1;
                        end
                    end
                end
            end
            m_armed = 1;
            m_npulse = edg ? 1 : 0;
            m_pos = 0;
            if (edg) m_pos_last = '0;
        end else if (edg && m_armed) begin
            m_npulse++;
            if (m_npulse == 1) begin
                m_pos = m_pos_now;
                m_pos_last = 8'(m_pos_now);
            end
        end
    endtask

    // Single compare process: outputs checked every cycle against the model, then the model advances.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
            chk("rst_data_out", 32'(bus.data_out), 32'd0);
            chk("rst_overflow", 32'(bus.overflow), 32'd0);
            chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
            chk("rst_err_code", 32'(bus.err_code), 32'd0);
            chk("rst_pos_last", 32'(bus.pos_last), 32'd0);
        end else begin
            chk("data_valid", 32'(bus.data_valid), 32'(m_valid));
            chk("data_out", 32'(bus.data_out), 32'(m_data));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
            chk("err_code", 32'(bus.err_code), 32'(m_err_code));
            chk("pos_last", 32'(bus.pos_last), 32'(m_pos_last));
            if (bus.data_valid && bus.data_ready) dut_words.push_back(bus.data_out);
            if (bus.frame_err) dut_ferr_cnt++;
            if (bus.overflow) dut_ovf_cnt++;
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: strobe at k=0, 2-cycle RF pulses rising at p0/p1 (negative = absent).
    task automatic run_frame(input int len, input int p0, input int p1);
        for (int k = 0; k < len; k++) begin
            bus.frame_stb = (k == 0);
            bus.rf_evt = ((p0 >= 0) && (k >= p0) && (k < p0 + 2)) ||
                         ((p1 >= 0) && (k >= p1) && (k < p1 + 2));
            if (rand_ready) bus.data_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.rf_evt = 1'b0;
    endtask

    task automatic run_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) run_frame(120, w[i] ? 70 : 30, -1);
    endtask

    task automatic close_frame();
        bus.frame_stb = 1'b1;
        bus.rf_evt = 1'b0;
        tick();
        bus.frame_stb = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_word(input string nm, input logic [7:0] exp);
        chk({nm, "_cnt"}, 32'(dut_words.size()), 32'd1);
        chk({nm, "_model_cnt"}, 32'(model_words.size()), 32'd1);
        if (dut_words.size() > 0) chk(nm, 32'(dut_words[0]), 32'(exp));
        if (model_words.size() > 0) chk({nm, "_model"}, 32'(model_words[0]), 32'(exp));
        dut_words.delete();
        model_words.delete();
    endtask

    initial begin
        int t2[8];
        int t3[8];
        int e0;
        int kind, p0, p1;
        t2 = '{70, 30, 70, 70, 30, 30, 70, 30};
        t3 = '{49, 50, 49, 50, 50, 49, 49, 50};

        rst = 1'b1;
        bus.frame_stb = 1'b0;
        bus.rf_evt = 1'b0;
        bus.data_ready = 1'b1;
        repeat (3) tick();
        chk("reset_valid", 32'(bus.data_valid), 32'd0);
        chk("reset_pos_last", 32'(bus.pos_last), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // All-early frames
        run_word(8'h00);
        close_frame();
        check_word("t1_word", 8'h00);

        // Mixed pattern
        for (int i = 0; i < 8; i++) run_frame(120, t2[i], -1);
        close_frame();
        check_word("t2_word", 8'hB2);

        // Threshold boundary 49 / 50
        for (int i = 0; i < 8; i++) run_frame(120, t3[i], -1);
        close_frame();
        check_word("t3_word", 8'h59);

        // Double pulse then missing pulse, each discarding the partial word
        run_frame(120, 30, -1);
        run_frame(120, 70, -1);
        e0 = dut_ferr_cnt;
        run_frame(120, 30, 60);
        run_frame(120, 70, -1);
        chk("t4_dbl_code", 32'(bus.err_code), 32'd2);
        chk("t4_dbl_pulses", 32'(dut_ferr_cnt - e0), 32'd1);
        run_frame(120, 30, -1);
        run_frame(120, -1, -1);
        e0 = dut_ferr_cnt;
        run_word(8'hA5);
        chk("t4_none_code", 32'(bus.err_code), 32'd1);
        chk("t4_none_pulses", 32'(dut_ferr_cnt - e0), 32'd1);
        close_frame();
        check_word("t4_word", 8'hA5);

        // Backpressure across two words
        bus.data_ready = 1'b0;
        e0 = dut_ovf_cnt;
        run_word(8'hC3);
        run_word(8'h3C);
        close_frame();
        chk("t5_ovf_pulses", 32'(dut_ovf_cnt - e0), 32'd1);
        chk("t5_held_valid", 32'(bus.data_valid), 32'd1);
        chk("t5_held_data", 32'(bus.data_out), 32'hC3);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        chk("t5_valid_drop", 32'(bus.data_valid), 32'd0);
        check_word("t5_word", 8'hC3);
        bus.data_ready = 1'b1;

        // Reset in the middle of frame 5
        run_frame(120, 30, -1);
        run_frame(120, 70, -1);
        run_frame(120, 30, -1);
        run_frame(120, 70, -1);
        run_frame(40, 20, -1);
        #19 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(bus.data_valid), 32'd0);
        chk("t6_rst_data", 32'(bus.data_out), 32'd0);
        chk("t6_rst_ovf", 32'(bus.overflow), 32'd0);
        chk("t6_rst_ferr", 32'(bus.frame_err), 32'd0);
        chk("t6_rst_code", 32'(bus.err_code), 32'd0);
        chk("t6_rst_pos", 32'(bus.pos_last), 32'd0);
        bus.rf_evt = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        bus.rf_evt = 1'b0;
        repeat (2) tick();
        run_frame(120, 40, -1);
        chk("t6_pos_40", 32'(bus.pos_last), 32'd40);
        run_frame(120, 0, -1);
        chk("t6_pos_coincident", 32'(bus.pos_last), 32'd0);
        run_frame(120, 70, -1);
        run_frame(120, 30, -1);
        run_frame(120, 70, -1);
        run_frame(120, 70, -1);
        run_frame(120, 30, -1);
        run_frame(120, 70, -1);
        close_frame();
        check_word("t6_word", 8'h2D);

        // Counter saturation
        run_frame(300, 280, -1);
        chk("sat_pos", 32'(bus.pos_last), 32'd255);
        run_frame(120, 30, -1);

        // Randomized frames with random backpressure
        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            p0 = $urandom_range(0, 110);
            p1 = -1;
            if (kind == 0) p0 = -1;
            else if (kind == 1) begin
                p0 = $urandom_range(0, 60);
                p1 = p0 + 3 + $urandom_range(0, 50);
            end
            run_frame(120, p0, p1);
        end
        rand_ready = 0;
        bus.data_ready = 1'b1;
        close_frame();
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
